// File: rtl/biu_pkg.sv
// biu_pkg: shared constants, opcode encodings and word-format select for the prefetch queue.
package biu_pkg;
  localparam int QDEPTH = 6;
  localparam logic [19:0] RESET_ADDR = 20'hFFFF0;
  localparam logic [7:0] OP_GRP80 = 8'h80;
  localparam logic [7:0] OP_GRP81 = 8'h81;
  localparam logic [7:0] OP_GRP83 = 8'h83;
  localparam logic [7:0] OP_MOV_RI8 = 8'hB0;
  localparam logic [7:0] OP_MOV_RI16 = 8'hB8;
  localparam logic [1:0] MOD_REG = 2'b11;
  localparam logic [2:0] LEN1 = 3'd1;
  localparam logic [2:0] LEN2 = 3'd2;
  localparam logic [2:0] LEN3 = 3'd3;
  localparam logic [2:0] LEN4 = 3'd4;
  typedef enum logic [2:0] {FMT_BAD, FMT_RR, FMT_G80, FMT_G81, FMT_G83, FMT_RI8, FMT_RI16} fmt_e;
endpackage

// File: rtl/biu_len_decode.sv
// biu_len_decode: head opcode and modrm mod field -> instruction length, word format, illegal flag.
module biu_len_decode import biu_pkg::*; (
  input  logic [7:0] op_i,
  input  logic [1:0] mod_i,
  output logic [2:0] len_o,
  output fmt_e       fmt_o,
  output logic       illegal_o
);
  logic rr;
  assign rr = (op_i[7:6] == 2'b00 && !op_i[2]) || op_i[7:2] == OP_GRP80[7:2] + 6'd2;
  assign fmt_o = rr ? FMT_RR :
                 op_i == OP_GRP80 ? FMT_G80 :
                 op_i == OP_GRP81 ? FMT_G81 :
                 op_i == OP_GRP83 ? FMT_G83 :
                 op_i[7:3] == OP_MOV_RI8[7:3] ? FMT_RI8 :
                 op_i[7:3] == OP_MOV_RI16[7:3] ? FMT_RI16 : FMT_BAD;
  assign len_o = fmt_o == FMT_G81 ? LEN4 :
                 fmt_o inside {FMT_G80, FMT_G83, FMT_RI16} ? LEN3 :
                 fmt_o inside {FMT_RR, FMT_RI8} ? LEN2 : LEN1;
  // modrm-carrying forms only support register operands
  assign illegal_o = fmt_o == FMT_BAD ||
                     (fmt_o inside {FMT_RR, FMT_G80, FMT_G81, FMT_G83} && mod_i != MOD_REG);
endmodule

// File: rtl/biu_prefetch_queue.sv
// biu_prefetch_queue: byte prefetch FIFO with instruction assembly into a registered valid/ready word.
module biu_prefetch_queue import biu_pkg::*; #(
  parameter int QDEPTH = biu_pkg::QDEPTH,
  parameter logic [19:0] RESET_ADDR = biu_pkg::RESET_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [19:0] flush_addr,
  output logic        fetch_req,
  output logic [19:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [7:0]  fetch_data,
  input  logic        eu_ready,
  output logic        inst_valid,
  output logic [31:0] instruction_and_imm,
  output logic [2:0]  inst_len,
  output logic        illegal,
  output logic [2:0]  queue_count
);
  localparam logic [3:0] QD = 4'(QDEPTH);
  logic [7:0] q_q [QDEPTH];
  logic [2:0] head_q, head_d, tail_q, tail_d, count_q, count_d, len_q, dec_len;
  logic [19:0] addr_q;
  logic fetch_en_q, valid_q, valid_d, illegal_q, dec_ill, push, load;
  logic [31:0] word_q, word_d;
  logic [7:0] b0, b1, b2, b3;
  fmt_e fmt;
  function automatic logic [2:0] wrap(input logic [2:0] p, input logic [2:0] n);
    logic [3:0] s;
    s = {1'b0, p} + {1'b0, n};
    return s >= QD ? 3'(s - QD) : s[2:0];
  endfunction
  assign b0 = q_q[head_q];
  assign b1 = q_q[wrap(head_q, 3'd1)];
  assign b2 = q_q[wrap(head_q, 3'd2)];
  assign b3 = q_q[wrap(head_q, 3'd3)];
  biu_len_decode u_dec (.op_i(b0), .mod_i(b1[7:6]), .len_o(dec_len), .fmt_o(fmt), .illegal_o(dec_ill));
  assign fetch_req = fetch_en_q && {1'b0, count_q} < QD;
  assign push = fetch_req && fetch_ack;
  // count_q only reflects bytes pushed in earlier cycles, so decode never sees an in-flight byte
  assign load = (!valid_q || eu_ready) && count_q >= dec_len;
  assign count_d = count_q + 3'(push) - (load ? dec_len : 3'd0);
  assign head_d = load ? wrap(head_q, dec_len) : head_q;
  assign tail_d = push ? wrap(tail_q, 3'd1) : tail_q;
  assign valid_d = load || (valid_q && !eu_ready);
  assign word_d = fmt == FMT_RR   ? {16'h0000, b0, b1} :
                  fmt == FMT_G80  ? {b0, b1, 8'h00, b2} :
                  fmt == FMT_G81  ? {b0, b1, b3, b2} :
                  fmt == FMT_G83  ? {b0, b1, {8{b2[7]}}, b2} :
                  fmt == FMT_RI8  ? {b0, 16'h0000, b1} :
                  fmt == FMT_RI16 ? {b0, 8'h00, b2, b1} : {16'h0000, b0, 8'h00};
  always_ff @(posedge clk)
    if (push && !reset && !flush) q_q[tail_q] <= fetch_data;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      addr_q <= reset ? RESET_ADDR : flush_addr;
      fetch_en_q <= 1'b0;
      valid_q <= 1'b0;
      word_q <= '0;
      len_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q <= head_d;
      tail_q <= tail_d;
      addr_q <= addr_q + 20'(push);
      fetch_en_q <= 1'b1;
      valid_q <= valid_d;
      if (load) begin
        word_q <= word_d;
        len_q <= dec_len;
        illegal_q <= dec_ill;
      end
    end
  end
  assign fetch_addr = addr_q;
  assign inst_valid = valid_q;
  assign instruction_and_imm = word_q;
  assign inst_len = len_q;
  assign illegal = illegal_q;
  assign queue_count = count_q;
endmodule

// File: tb/tb_biu_prefetch_queue.sv
// tb_biu_prefetch_queue: directed checks of fetch, assembly, stall, flush and address wrap.
module tb_biu_prefetch_queue;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, fetch_ack = 1'b0, eu_ready = 1'b0;
  logic [19:0] flush_addr = '0, base = 20'hFFFF0;
  logic fetch_req, inst_valid, illegal;
  logic [19:0] fetch_addr;
  logic [7:0] fetch_data;
  logic [31:0] instruction_and_imm;
  logic [2:0] inst_len, queue_count;
  logic [7:0] img [64];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  assign fetch_data = img[6'(fetch_addr - base)];
  biu_prefetch_queue dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_addr(flush_addr),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .eu_ready(eu_ready), .inst_valid(inst_valid), .instruction_and_imm(instruction_and_imm),
    .inst_len(inst_len), .illegal(illegal), .queue_count(queue_count)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    step();
    while (!inst_valid && n < 20) begin
      step();
      n++;
    end
    tests++;
    assert (n < 20) else begin
      fails++;
      $error("FAIL %s: observed timeout expected inst_valid within 20 cycles", tag);
    end
  endtask
  initial begin
    for (int i = 0; i < 64; i++) img[i] = 8'h90;
    img[0] = 8'hB8; img[1] = 8'h34; img[2] = 8'h12;
    img[3] = 8'h01; img[4] = 8'hC8;
    img[5] = 8'h83; img[6] = 8'hC0; img[7] = 8'hFF;
    img[8] = 8'hF4;
    img[9] = 8'h01; img[10] = 8'h06;
    img[11] = 8'hB0; img[12] = 8'h55;
    img[13] = 8'h88; img[14] = 8'hC1;
    step();
    step();
    chk("rst_req", 32'(fetch_req), 32'd0);
    chk("rst_addr", 32'(fetch_addr), 32'hFFFF0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_count", 32'(queue_count), 32'd0);
    chk("rst_word", instruction_and_imm, 32'd0);
    chk("rst_len", 32'(inst_len), 32'd0);
    reset = 1'b0;
    step();
    chk("req_after_rst", 32'(fetch_req), 32'd1);
    chk("addr_first", 32'(fetch_addr), 32'hFFFF0);
    fetch_ack = 1'b1;
    eu_ready = 1'b1;
    step();
    chk("addr_1", 32'(fetch_addr), 32'hFFFF1);
    chk("count_1", 32'(queue_count), 32'd1);
    step();
    step();
    chk("addr_3", 32'(fetch_addr), 32'hFFFF3);
    chk("valid_not_yet", 32'(inst_valid), 32'd0);
    step();
    chk("valid_b8", 32'(inst_valid), 32'd1);
    chk("word_b8", instruction_and_imm, 32'hB800_1234);
    chk("len_b8", 32'(inst_len), 32'd3);
    chk("ill_b8", 32'(illegal), 32'd0);
    wait_valid("wait_add");
    chk("word_add", instruction_and_imm, 32'h0000_01C8);
    chk("len_add", 32'(inst_len), 32'd2);
    chk("ill_add", 32'(illegal), 32'd0);
    wait_valid("wait_83");
    chk("word_83", instruction_and_imm, 32'h83C0_FFFF);
    chk("len_83", 32'(inst_len), 32'd3);
    chk("ill_83", 32'(illegal), 32'd0);
    wait_valid("wait_f4");
    chk("word_f4", instruction_and_imm, 32'h0000_F400);
    chk("len_f4", 32'(inst_len), 32'd1);
    chk("ill_f4", 32'(illegal), 32'd1);
    wait_valid("wait_0106");
    chk("word_0106", instruction_and_imm, 32'h0000_0106);
    chk("len_0106", 32'(inst_len), 32'd2);
    chk("ill_0106", 32'(illegal), 32'd1);
    eu_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("stall_count", 32'(queue_count), 32'd6);
    chk("stall_req", 32'(fetch_req), 32'd0);
    chk("stall_word", instruction_and_imm, 32'h0000_0106);
    chk("stall_valid", 32'(inst_valid), 32'd1);
    chk("stall_addr", 32'(fetch_addr), 32'h00001);
    eu_ready = 1'b1;
    step();
    eu_ready = 1'b0;
    chk("pulse_word", instruction_and_imm, 32'hB000_0055);
    chk("pulse_count", 32'(queue_count), 32'd4);
    chk("pulse_req", 32'(fetch_req), 32'd1);
    chk("pulse_valid", 32'(inst_valid), 32'd1);
    flush = 1'b1;
    flush_addr = 20'h01000;
    step();
    flush = 1'b0;
    chk("fl_valid", 32'(inst_valid), 32'd0);
    chk("fl_count", 32'(queue_count), 32'd0);
    chk("fl_req", 32'(fetch_req), 32'd0);
    chk("fl_addr", 32'(fetch_addr), 32'h01000);
    step();
    chk("fl_req_resume", 32'(fetch_req), 32'd1);
    chk("fl_addr_resume", 32'(fetch_addr), 32'h01000);
    flush = 1'b1;
    flush_addr = 20'hFFFFF;
    base = 20'hFFFFF;
    img[0] = 8'h81; img[1] = 8'hC3; img[2] = 8'h34; img[3] = 8'h12;
    eu_ready = 1'b1;
    step();
    flush = 1'b0;
    chk("wr_idle_req", 32'(fetch_req), 32'd0);
    step();
    chk("wr_req", 32'(fetch_req), 32'd1);
    chk("wr_addr0", 32'(fetch_addr), 32'hFFFFF);
    step();
    chk("wr_addr1", 32'(fetch_addr), 32'h00000);
    wait_valid("wait_81");
    chk("word_81", instruction_and_imm, 32'h81C3_1234);
    chk("len_81", 32'(inst_len), 32'd4);
    chk("ill_81", 32'(illegal), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
